// File: rtl/pixel_readout_rx_if.sv
// Pixel data bus plus the decoded pixel stream leaving the receiver.
// Stream handshake: a beat transfers on a rising clk edge with out_valid & out_ready;
// while out_valid & !out_ready the payload (data/index/sof/eof) holds steady.
interface pixel_readout_rx_if;
   logic        read1;
   logic        read2;
   logic [15:0] pixelDataOut1;
   logic [15:0] pixelDataOut2;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_index;
   logic        out_sof;
   logic        out_eof;
   logic        overflow;
   logic [7:0]  frame_count;

   modport master (
      output read1, read2, pixelDataOut1, pixelDataOut2, out_ready,
      input  out_valid, out_data, out_index, out_sof, out_eof, overflow, frame_count
   );

   modport slave (
      input  read1, read2, pixelDataOut1, pixelDataOut2, out_ready,
      output out_valid, out_data, out_index, out_sof, out_eof, overflow, frame_count
   );
endinterface

// File: rtl/pixel_readout_rx.sv
// Captures gray-coded pixel rows during read1/read2 phases, decodes them and
// streams one binary pixel per beat from a small FIFO.
module pixel_readout_rx #(
   parameter int SAMPLE_DELAY = 2,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   pixel_readout_rx_if.slave     pix,
   output logic [2:0]            state_dbg
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [3:0]  DLY       = 4'(SAMPLE_DELAY - 1);
   localparam logic [AW:0] FREE2_MAX = (AW+1)'(FIFO_DEPTH - 2);

   // state_dbg encoding: 0 IDLE, 1 WAIT1, 2 CAP1, 3 WAIT2, 4 CAP2
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT1 = 3'd1,
      CAP1  = 3'd2,
      WAIT2 = 3'd3,
      CAP2  = 3'd4
   } state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic        w2_cnt, w2_cnt_nx;
   logic        read1_q, read2_q;
   logic        r1_rise, r2_rise;
   logic        cap, cap_row2;

   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, wr_ptr_p1, rd_ptr;
   logic [AW:0]   count, count_add, count_sub;
   logic          free_ok, write, pop;
   logic [15:0]   row_word;
   logic [7:0]    d_hi, d_lo;
   logic [9:0]    head;
   logic          overflow_q;
   logic [7:0]    frame_cnt_q;

   function automatic logic [7:0] gray_to_bin(input logic [7:0] g);
      logic [7:0] b;
      b[7] = g[7];
      for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   assign r1_rise = pix.read1 & ~read1_q;
   assign r2_rise = pix.read2 & ~read2_q;

   // WAIT2 has two phases: waiting for the read2 edge (w2_cnt=0), then counting down.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      w2_cnt_nx = w2_cnt;
      cap       = 1'b0;
      cap_row2  = 1'b0;
      case (state)
         IDLE: begin
            if (r1_rise) begin
               state_nx = WAIT1;
               cnt_nx   = DLY;
            end
         end
         WAIT1: begin
            if (!pix.read1)     state_nx = IDLE;
            else if (cnt == '0) state_nx = CAP1;
            else                cnt_nx   = cnt - 4'd1;
         end
         CAP1: begin
            cap       = 1'b1;
            state_nx  = WAIT2;
            w2_cnt_nx = 1'b0;
         end
         WAIT2: begin
            if (r1_rise) begin
               state_nx  = WAIT1;
               cnt_nx    = DLY;
               w2_cnt_nx = 1'b0;
            end else if (!w2_cnt) begin
               if (r2_rise) begin
                  w2_cnt_nx = 1'b1;
                  cnt_nx    = DLY;
               end
            end else if (!pix.read2) begin
               state_nx  = IDLE;
               w2_cnt_nx = 1'b0;
            end else if (cnt == '0) begin
               state_nx  = CAP2;
               w2_cnt_nx = 1'b0;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         CAP2: begin
            cap      = 1'b1;
            cap_row2 = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Space is judged before any same-cycle pop, so a row needs two free slots now.
   assign free_ok   = (count <= FREE2_MAX);
   assign write     = cap & free_ok;
   assign pop       = pix.out_valid & pix.out_ready;
   assign count_add = write ? (AW+1)'(2) : '0;
   assign count_sub = pop   ? (AW+1)'(1) : '0;
   assign wr_ptr_p1 = wr_ptr + AW'(1);

   assign row_word = cap_row2 ? pix.pixelDataOut2 : pix.pixelDataOut1;
   assign d_hi     = gray_to_bin(row_word[15:8]);
   assign d_lo     = gray_to_bin(row_word[7:0]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         w2_cnt      <= 1'b0;
         read1_q     <= 1'b0;
         read2_q     <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         overflow_q  <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         w2_cnt  <= w2_cnt_nx;
         read1_q <= pix.read1;
         read2_q <= pix.read2;
         if (write) wr_ptr <= wr_ptr + AW'(2);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         count <= count + count_add - count_sub;
         if (cap && !free_ok)    overflow_q  <= 1'b1;
         if (cap_row2 && write)  frame_cnt_q <= frame_cnt_q + 8'd1;
      end
   end

   // Storage needs no reset: pointers and count define what is live.
   always_ff @(posedge clk) begin
      if (write) begin
         mem[wr_ptr]    <= {cap_row2, 1'b0, d_hi};
         mem[wr_ptr_p1] <= {cap_row2, 1'b1, d_lo};
      end
   end

   assign head            = mem[rd_ptr];
   assign pix.out_valid   = (count != '0);
   assign pix.out_data    = pix.out_valid ? head[7:0] : 8'd0;
   assign pix.out_index   = pix.out_valid ? head[9:8] : 2'd0;
   assign pix.out_sof     = pix.out_valid & (head[9:8] == 2'd0);
   assign pix.out_eof     = pix.out_valid & (head[9:8] == 2'd3);
   assign pix.overflow    = overflow_q;
   assign pix.frame_count = frame_cnt_q;
   assign state_dbg       = state;

endmodule

// File: tb/tb_pixel_readout_rx.sv
// Self-checking bench for pixel_readout_rx: row stimulus, expected-beat queue, final report.
module tb_pixel_readout_rx;

   localparam int SD    = 2;
   localparam int DEPTH = 4;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WAIT2 = 3'd3;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] state_dbg;

   pixel_readout_rx_if pix();

   pixel_readout_rx #(.SAMPLE_DELAY(SD), .FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .pix       (pix),
      .state_dbg (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // scoreboard state: {sof, eof, index, data}
   logic [11:0] exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          beats    = 0;
   logic [7:0]  exp_fc   = 8'd0;
   logic [11:0] beat;
   logic [11:0] exp_beat;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference decode: each binary bit is the XOR of all gray bits at or above it.
   function automatic logic [7:0] g2b(input logic [7:0] g);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   task automatic push_pix(input logic [1:0] idx, input logic [7:0] val);
      exp_q.push_back({idx == 2'd0, idx == 2'd3, idx, val});
   endtask

   task automatic push_row(input logic row2, input logic [15:0] g);
      push_pix({row2, 1'b0}, g2b(g[15:8]));
      push_pix({row2, 1'b1}, g2b(g[7:0]));
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic row(input logic row2, input logic [15:0] g, input int hold, input int gap);
      if (row2) begin
         pix.read2 = 1'b1; pix.pixelDataOut2 = g;
      end else begin
         pix.read1 = 1'b1; pix.pixelDataOut1 = g;
      end
      repeat (hold) tick();
      if (row2) pix.read2 = 1'b0;
      else      pix.read1 = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic random_frame();
      logic [15:0] g1, g2;
      g1 = 16'($urandom);
      g2 = 16'($urandom);
      push_row(1'b0, g1);
      row(1'b0, g1, $urandom_range(SD + 1, 6), $urandom_range(1, 3));
      push_row(1'b1, g2);
      row(1'b1, g2, $urandom_range(SD + 1, 6), $urandom_range(1, 3));
      exp_fc++;
   endtask

   task automatic wait_drain(input int max_cycles);
      for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
      check("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   // output monitor: compare on accepted beats, verify payload holds while stalled
   always @(negedge clk) begin
      if (!reset && pix.out_valid) begin
         beat = {pix.out_sof, pix.out_eof, pix.out_index, pix.out_data};
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(beat), 32'hFFFF_FFFF);
         end else if (pix.out_ready) begin
            exp_beat = exp_q.pop_front();
            check("beat", 32'(beat), 32'(exp_beat));
            beats++;
         end else begin
            check("hold", 32'(beat), 32'(exp_q[0]));
         end
      end
   end

   logic [15:0] g_lat;
   int          beats0;

   initial begin
      reset = 1'b1;
      pix.read1 = 1'b0; pix.read2 = 1'b0;
      pix.pixelDataOut1 = '0; pix.pixelDataOut2 = '0;
      pix.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(pix.out_valid), 32'd0);
      check("rst_data",  32'(pix.out_data),  32'd0);
      check("rst_index", 32'(pix.out_index), 32'd0);
      check("rst_sof",   32'(pix.out_sof),   32'd0);
      check("rst_eof",   32'(pix.out_eof),   32'd0);
      check("rst_ovf",   32'(pix.overflow),  32'd0);
      check("rst_fc",    32'(pix.frame_count), 32'd0);
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      reset = 1'b0;
      tick();

      // nominal frame, expected beats written out by hand
      pix.out_ready = 1'b1;
      push_pix(2'd0, 8'hFF); push_pix(2'd1, 8'h7F);
      row(1'b0, 16'h8040, 5, 2);
      push_pix(2'd2, 8'h80); push_pix(2'd3, 8'hAA);
      row(1'b1, 16'hC0FF, 5, 2);
      exp_fc++;
      wait_drain(20);
      check("nom_fc", 32'(pix.frame_count), 32'd1);

      // latency: out_valid first high SD+2 cycles after the read edge; bus change after capture ignored
      pix.out_ready = 1'b0;
      g_lat = 16'h1234;
      push_row(1'b0, g_lat);
      pix.read1 = 1'b1; pix.pixelDataOut1 = g_lat;
      for (int c = 0; c <= SD + 2; c++) begin
         @(negedge clk);
         check($sformatf("lat_valid_c%0d", c), 32'(pix.out_valid), 32'(c >= SD + 2));
         tick();
         if (c == SD + 1) pix.pixelDataOut1 = ~g_lat;
      end
      pix.read1 = 1'b0;
      tick();
      pix.out_ready = 1'b1;
      push_row(1'b1, 16'h5A3C);
      row(1'b1, 16'h5A3C, 4, 2);
      exp_fc++;
      wait_drain(20);
      check("lat_fc", 32'(pix.frame_count), 32'(exp_fc));

      // short strobe: too short to capture
      pix.read1 = 1'b1; pix.pixelDataOut1 = 16'hFFFF;
      tick();
      pix.read1 = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("short_valid", 32'(pix.out_valid), 32'd0);
         tick();
      end
      check("short_state", 32'(state_dbg), 32'(ST_IDLE));

      // orphan read2, then read1, read1, read2
      row(1'b1, 16'h0F0F, 5, 2);
      check("orphan_valid", 32'(pix.out_valid), 32'd0);
      push_row(1'b0, 16'hA1B2);
      row(1'b0, 16'hA1B2, 4, 2);
      push_row(1'b0, 16'hC3D4);
      row(1'b0, 16'hC3D4, 4, 2);
      push_row(1'b1, 16'hE5F6);
      row(1'b1, 16'hE5F6, 4, 2);
      exp_fc++;
      wait_drain(20);
      check("orphan_fc", 32'(pix.frame_count), 32'(exp_fc));

      // backpressure: first frame fills the FIFO exactly, second frame dropped
      pix.out_ready = 1'b0;
      push_row(1'b0, 16'h1111);
      row(1'b0, 16'h1111, 4, 2);
      push_row(1'b1, 16'h2222);
      row(1'b1, 16'h2222, 4, 2);
      exp_fc++;
      @(negedge clk);
      check("ovf_before", 32'(pix.overflow), 32'd0);
      tick();
      row(1'b0, 16'h3333, 4, 2);
      row(1'b1, 16'h4444, 4, 2);
      @(negedge clk);
      check("ovf_after", 32'(pix.overflow), 32'd1);
      check("ovf_fc", 32'(pix.frame_count), 32'(exp_fc));
      tick();
      beats0 = beats;
      pix.out_ready = 1'b1;
      wait_drain(20);
      repeat (3) tick();
      check("ovf_drain_beats", 32'(beats - beats0), 32'd4);
      @(negedge clk);
      check("ovf_empty", 32'(pix.out_valid), 32'd0);
      tick();

      // reset during WAIT2 with two entries queued
      pix.out_ready = 1'b0;
      push_row(1'b0, 16'h7E81);
      row(1'b0, 16'h7E81, 4, 2);
      @(negedge clk);
      check("pre_rst_valid", 32'(pix.out_valid), 32'd1);
      check("pre_rst_state", 32'(state_dbg), 32'(ST_WAIT2));
      #1 reset = 1'b1;
      #1;
      check("mid_rst_valid", 32'(pix.out_valid), 32'd0);
      check("mid_rst_data",  32'(pix.out_data),  32'd0);
      check("mid_rst_sof",   32'(pix.out_sof),   32'd0);
      check("mid_rst_ovf",   32'(pix.overflow),  32'd0);
      check("mid_rst_fc",    32'(pix.frame_count), 32'd0);
      check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
      exp_q.delete();
      exp_fc = 8'd0;
      @(negedge clk);
      reset = 1'b0;
      tick();
      pix.out_ready = 1'b1;
      random_frame();
      wait_drain(20);
      check("post_rst_fc", 32'(pix.frame_count), 32'd1);

      // frame_count wrap: 256 frames since reset brings it back to 0
      for (int f = 0; f < 254; f++) random_frame();
      wait_drain(20);
      check("fc_pre_wrap", 32'(pix.frame_count), 32'd255);
      random_frame();
      wait_drain(20);
      check("fc_wrap", 32'(pix.frame_count), 32'd0);

      @(negedge clk);
      check("final_empty", 32'(pix.out_valid), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
